heap_cmd_issue: RTL and testbench
=================================

// Module: heap_cmd_issue
// PURPOSE
//  Upstream issue stage for the heap custom-SIMD unit. Buffers push/pop commands from core decode,
//  tracks heap occupancy, and refuses illegal ops (push-full, pop-empty, bad opcode) locally.
//  Issues one command at a time to the heap unit and returns one tagged write-back per command,
//  in order. Core never sees heap busy/timing.
// PARAMETERS
//  DEPTH      4    command FIFO entries (power of 2, >=2)
//  HEAP_SIZE  256  heap capacity; must equal the heap unit's array size
//  DATA_W     32   command/result data width
//  RESP_LAT   5    cycles from hp_v to valid hp_out_data (heap pipe depth), >=1
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  in_v         in   1       command valid from core
//  in_ready     out  1       FIFO can accept (count < DEPTH)
//  in_op        in   2       1=push, 2=pop, else illegal
//  in_rd        in   5       destination register tag
//  in_data      in   DATA_W  push value (ignored for pop)
//  hp_v         out  1       one-cycle issue strobe to heap (drives its in_v)
//  hp_op        out  3       opcode to heap (drives vrd1): 1 push, 2 pop
//  hp_rd        out  5       tag to heap
//  hp_data      out  DATA_W  push value to heap
//  hp_out_v     in   1       heap result valid
//  hp_out_data  in   DATA_W  heap pop result
//  wb_v         out  1       one-cycle write-back strobe
//  wb_rd        out  5       write-back tag
//  wb_data      out  DATA_W  pop: popped value; push: occupancy after push; error: 0
//  wb_err       out  1       command refused or heap gave no result
//  occupancy    out  9       current heap element count, 0..HEAP_SIZE
//  idle         out  1       FIFO empty and FSM in IDLE
// BEHAVIOUR
//  Reset (async): FIFO empty, occ=0, FSM=IDLE; in_ready=1, idle=1, all other outputs 0.
//   Reset mid-operation drops queued/in-flight commands; no wb issued. Heap shares this reset.
//  Accept on in_v&&in_ready; in_ready from registered count, so a full FIFO does not accept even
//   if a dequeue happens the same cycle. Accept and dequeue in one cycle when not full: count unchanged.
//  FSM states IDLE, ISSUE, WAIT, RESP:
//   IDLE: FIFO non-empty -> check head. Illegal = (push && occ==HEAP_SIZE) || (pop && occ==0)
//    || op not 1/2. Illegal: dequeue, load wb regs (err=1, data=0) -> RESP. Legal -> ISSUE.
//   ISSUE: hp_v=1 for exactly one cycle with hp_op/hp_rd/hp_data from head; dequeue;
//    occ +1 (push) or -1 (pop); timer=RESP_LAT-1 -> WAIT.
//   WAIT: decrement timer; at 0 sample hp_out_v/hp_out_data -> RESP.
//    Pop with hp_out_v=0: wb_err=1, wb_data=0. Push: wb_data=occ (post-push), err=0.
//   RESP: wb_v=1 one cycle -> IDLE.
//  Latency (empty FIFO, accept at cycle 0):
//   legal: hp_v at cycle 2, wb_v at cycle 2+RESP_LAT+1;
//   illegal: wb_v at cycle 2, hp_v never asserted.
//  Strictly one command in flight; wb order equals accept order.
//  hp_* outputs held 0 when hp_v=0. wb_* held 0 when wb_v=0.
//  occ saturates by construction (illegal checks); never wraps. occ updated only in ISSUE.
//  FIFO pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
// STRUCTURE
//  Shared package heap_pkg: OP_PUSH=1, OP_POP=2, HEAP_SIZE, state encoding (2-bit), cmd record
//   width (2+5+DATA_W).
//  One sub-module: heap_cmd_fifo (DEPTH x cmd, registered count, push/pop/full/empty). FSM,
//   occupancy counter, latency timer and wb registers live in heap_cmd_issue.
// TESTING
//  1 Push 10,30,20 back-to-back, then 3 pops -> hp_v 3x op1; wb pushes data 1,2,3;
//    pops return 30,20,10, err=0; occupancy ends 0.
//  2 Pop after reset -> no hp_v; wb_v 2 cycles after accept, wb_err=1, wb_data=0, wb_rd echoed.
//  3 HEAP_SIZE=4: 5 pushes -> 5th wb_err=1, no 5th hp_v, occupancy stays 4.
//  4 Hold in_v 8 cycles with DEPTH=4 -> in_ready drops after 4 accepts; all 8 wb in order, tags match.
//  5 in_op=3 -> wb_err=1, no hp_v; following push still issues normally.
//  6 Assert reset during WAIT of a pop -> no wb_v; all outputs 0; occupancy 0; in_ready=1
//    in the reset cycle.

Source files
------------

// File: rtl/heap_pkg.sv
// Shared constants for the heap issue stage: opcodes, capacity, FSM encoding and command packing.
// Purely declarative; no logic, no latency, no flow control.
package heap_pkg;

  localparam logic [1:0] OP_PUSH   = 2'd1;
  localparam logic [1:0] OP_POP    = 2'd2;
  localparam int         HEAP_SIZE = 256;
  localparam int         OCC_W     = 9;
  localparam int         RD_W      = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Command record is packed as {op, rd, data}
  function automatic int cmd_width(input int data_w);
    return 2 + RD_W + data_w;
  endfunction

endpackage

// File: rtl/heap_cmd_issue_if.sv
// Core-command, heap-issue and write-back signals of the heap issue stage.
// master = issue stage, slave = core/heap side.
interface heap_cmd_issue_if #(
  parameter int DATA_W = 32
);
  logic              in_v;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [4:0]        in_rd;
  logic [DATA_W-1:0] in_data;

  logic              hp_v;
  logic [2:0]        hp_op;
  logic [4:0]        hp_rd;
  logic [DATA_W-1:0] hp_data;
  logic              hp_out_v;
  logic [DATA_W-1:0] hp_out_data;

  logic              wb_v;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;

  logic [8:0]        occupancy;
  logic              idle;

  modport master (
    input  in_v, in_op, in_rd, in_data, hp_out_v, hp_out_data,
    output in_ready, hp_v, hp_op, hp_rd, hp_data, wb_v, wb_rd, wb_data, wb_err, occupancy, idle
  );

  modport slave (
    output in_v, in_op, in_rd, in_data, hp_out_v, hp_out_data,
    input  in_ready, hp_v, hp_op, hp_rd, hp_data, wb_v, wb_rd, wb_data, wb_err, occupancy, idle
  );
endinterface

// File: rtl/heap_cmd_fifo.sv
// DEPTH-entry command FIFO with registered count; head visible combinationally, one-cycle write.
// Caller qualifies push with !full and pop with !empty; full/empty derive from the registered count.
module heap_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 39
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/heap_cmd_issue.sv
// Issue stage for the heap unit: queues core push/pop commands, refuses illegal ones, returns one in-order wb each.
// Latency legal accept->wb = RESP_LAT+3, illegal = 2; in_ready drops while FIFO is full (registered count).
module heap_cmd_issue #(
  parameter int DEPTH     = 4,
  parameter int HEAP_SIZE = heap_pkg::HEAP_SIZE,
  parameter int DATA_W    = 32,
  parameter int RESP_LAT  = 5
) (
  input logic              clk,
  input logic              reset,
  heap_cmd_issue_if.master bus
);
  import heap_pkg::*;

  localparam int CW = cmd_width(DATA_W);
  localparam int TW = $clog2(RESP_LAT) + 1;

  state_t             state;
  logic [OCC_W-1:0]   occ;
  logic [TW-1:0]      timer;
  logic [RD_W-1:0]    cur_rd;
  logic               cur_pop;
  logic [RD_W-1:0]    wb_rd_r;
  logic [DATA_W-1:0]  wb_data_r;
  logic               wb_err_r;

  logic               fifo_push;
  logic               fifo_pop;
  logic [CW-1:0]      head;
  logic               full;
  logic               empty;

  logic [1:0]         h_op;
  logic [RD_W-1:0]    h_rd;
  logic [DATA_W-1:0]  h_data;
  logic               is_push;
  logic               is_pop;
  logic               illegal;
  logic               issuing;

  assign fifo_push = bus.in_v && !full;

  heap_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat ({bus.in_op, bus.in_rd, bus.in_data}),
    .pop      (fifo_pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign {h_op, h_rd, h_data} = head;
  assign is_push = (h_op == OP_PUSH);
  assign is_pop  = (h_op == OP_POP);
  assign illegal = (is_push && occ == OCC_W'(HEAP_SIZE)) || (is_pop && occ == '0) || !(is_push || is_pop);
  assign issuing = (state == ST_ISSUE);

  // Illegal heads are retired straight from IDLE; legal ones leave the FIFO as they issue
  assign fifo_pop = issuing || (state == ST_IDLE && !empty && illegal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      occ       <= '0;
      timer     <= '0;
      cur_rd    <= '0;
      cur_pop   <= 1'b0;
      wb_rd_r   <= '0;
      wb_data_r <= '0;
      wb_err_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (illegal) begin
              wb_rd_r   <= h_rd;
              wb_data_r <= '0;
              wb_err_r  <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cur_rd  <= h_rd;
          cur_pop <= is_pop;
          occ     <= is_push ? occ + OCC_W'(1) : occ - OCC_W'(1);
          timer   <= TW'(RESP_LAT - 1);
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (timer == '0) begin
            wb_rd_r <= cur_rd;
            if (cur_pop) begin
              wb_data_r <= bus.hp_out_v ? bus.hp_out_data : '0;
              wb_err_r  <= !bus.hp_out_v;
            end else begin
              wb_data_r <= DATA_W'(occ);
              wb_err_r  <= 1'b0;
            end
            state <= ST_RESP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.hp_v      = issuing;
  assign bus.hp_op     = issuing ? {1'b0, h_op} : 3'd0;
  assign bus.hp_rd     = issuing ? h_rd : '0;
  assign bus.hp_data   = issuing ? h_data : '0;
  assign bus.wb_v      = (state == ST_RESP);
  assign bus.wb_rd     = bus.wb_v ? wb_rd_r : '0;
  assign bus.wb_data   = bus.wb_v ? wb_data_r : '0;
  assign bus.wb_err    = bus.wb_v && wb_err_r;
  assign bus.occupancy = occ;
  assign bus.idle      = empty && (state == ST_IDLE);
endmodule

// File: tb/tb_heap_cmd_issue.sv
// Scoreboard bench for heap_cmd_issue with a behavioural max-heap model behind the issue port.
module tb_heap_cmd_issue;
  localparam int DW = 32;
  localparam int RL = 5;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } wb_exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] data;
  } hp_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   saw_full = 1'b0;

  wb_exp_t wb_q[$];
  hp_exp_t hp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  heap_cmd_issue_if #(.DATA_W(DW)) bus ();

  heap_cmd_issue #(.DEPTH(4), .HEAP_SIZE(4), .DATA_W(DW), .RESP_LAT(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Heap unit model: max-heap, result appears RL cycles after the issue strobe
  logic [31:0] heap_arr[$];
  logic        pv [RL];
  logic [31:0] pd [RL];
  int          mi;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      heap_arr.delete();
      for (int i = 0; i < RL; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      for (int i = RL - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= 1'b0;
      pd[0] <= '0;
      if (bus.hp_v) begin
        if (bus.hp_op == 3'd1) begin
          heap_arr.push_back(bus.hp_data);
          pv[0] <= 1'b1;
        end else if (bus.hp_op == 3'd2 && heap_arr.size() > 0) begin
          mi = 0;
          for (int i = 1; i < heap_arr.size(); i++)
            if (heap_arr[i] > heap_arr[mi]) mi = i;
          pv[0] <= 1'b1;
          pd[0] <= heap_arr[mi];
          heap_arr.delete(mi);
        end
      end
    end
  end

  assign bus.hp_out_v    = pv[RL-1];
  assign bus.hp_out_data = pd[RL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents hp_v or wb_v
  wb_exp_t we;
  hp_exp_t he;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.hp_v) begin
        if (hp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hp_unexpected got op=%0d rd=%0d want no issue", bus.hp_op, bus.hp_rd);
        end else begin
          he = hp_q.pop_front();
          chk("hp_op", 64'(bus.hp_op), 64'(he.op));
          chk("hp_rd", 64'(bus.hp_rd), 64'(he.rd));
          chk("hp_data", 64'(bus.hp_data), 64'(he.data));
        end
      end else begin
        chk("hp_idle_zero", 64'({bus.hp_op, bus.hp_rd, bus.hp_data}), 64'd0);
      end
      if (bus.wb_v) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected got rd=%0d data=%0h want no wb", bus.wb_rd, bus.wb_data);
        end else begin
          we = wb_q.pop_front();
          chk("wb_rd", 64'(bus.wb_rd), 64'(we.rd));
          chk("wb_data", 64'(bus.wb_data), 64'(we.data));
          chk("wb_err", 64'(bus.wb_err), 64'(we.err));
          if (we.lat >= 0) chk("wb_latency", 64'(cyc - we.acc), 64'(we.lat));
        end
      end else begin
        chk("wb_idle_zero", 64'({bus.wb_rd, bus.wb_data, bus.wb_err}), 64'd0);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] d,
                      input bit exp_hp, input logic [31:0] wdata, input bit werr, input int lat);
    int n;
    wb_exp_t w;
    hp_exp_t h;
    n = 0;
    bus.in_v    = 1'b1;
    bus.in_op   = op;
    bus.in_rd   = rd;
    bus.in_data = d;
    while (!bus.in_ready && n < 100) begin
      saw_full = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout rd=%0d in_ready=0 want 1", rd);
      bus.in_v = 1'b0;
      return;
    end
    w.rd = rd; w.data = wdata; w.err = werr; w.lat = lat; w.acc = cyc;
    wb_q.push_back(w);
    if (exp_hp) begin
      h.op = {1'b0, op}; h.rd = rd; h.data = d;
      hp_q.push_back(h);
    end
    @(posedge clk);
    #1;
    bus.in_v = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((wb_q.size() != 0 || hp_q.size() != 0 || !bus.idle) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_%s pending wb=%0d hp=%0d want 0", name, wb_q.size(), hp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bus.in_v = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_hp", 64'({bus.hp_v, bus.hp_op, bus.hp_rd, bus.hp_data}), 64'd0);
    chk("rst_wb", 64'({bus.wb_v, bus.wb_rd, bus.wb_data, bus.wb_err}), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Pop on an empty heap is refused locally
    send(2'd2, 5'd3, 32'd0, 1'b0, 32'd0, 1'b1, 2);
    drain("pop_empty");
    chk("occ_pop_empty", 64'(bus.occupancy), 64'd0);

    // Three pushes then three pops: max-heap order
    send(2'd1, 5'd1, 32'd10, 1'b1, 32'd1, 1'b0, 8);
    send(2'd1, 5'd2, 32'd30, 1'b1, 32'd2, 1'b0, -1);
    send(2'd1, 5'd3, 32'd20, 1'b1, 32'd3, 1'b0, -1);
    send(2'd2, 5'd4, 32'd0, 1'b1, 32'd30, 1'b0, -1);
    send(2'd2, 5'd5, 32'd0, 1'b1, 32'd20, 1'b0, -1);
    send(2'd2, 5'd6, 32'd0, 1'b1, 32'd10, 1'b0, -1);
    drain("push_pop");
    chk("occ_push_pop", 64'(bus.occupancy), 64'd0);

    // Fill the 4-entry heap, fifth push refused
    send(2'd1, 5'd7, 32'd5, 1'b1, 32'd1, 1'b0, -1);
    send(2'd1, 5'd8, 32'd1, 1'b1, 32'd2, 1'b0, -1);
    send(2'd1, 5'd9, 32'd7, 1'b1, 32'd3, 1'b0, -1);
    send(2'd1, 5'd10, 32'd3, 1'b1, 32'd4, 1'b0, -1);
    send(2'd1, 5'd11, 32'd9, 1'b0, 32'd0, 1'b1, -1);
    drain("push_full");
    chk("occ_full", 64'(bus.occupancy), 64'd4);

    // Eight commands with in_v held: FIFO fills, order and tags preserved
    saw_full = 1'b0;
    send(2'd2, 5'd12, 32'd0, 1'b1, 32'd7, 1'b0, -1);
    send(2'd2, 5'd13, 32'd0, 1'b1, 32'd5, 1'b0, -1);
    send(2'd2, 5'd14, 32'd0, 1'b1, 32'd3, 1'b0, -1);
    send(2'd2, 5'd15, 32'd0, 1'b1, 32'd1, 1'b0, -1);
    send(2'd1, 5'd16, 32'd40, 1'b1, 32'd1, 1'b0, -1);
    send(2'd1, 5'd17, 32'd50, 1'b1, 32'd2, 1'b0, -1);
    send(2'd2, 5'd18, 32'd0, 1'b1, 32'd50, 1'b0, -1);
    send(2'd2, 5'd19, 32'd0, 1'b1, 32'd40, 1'b0, -1);
    chk("in_ready_dropped", 64'(saw_full), 64'd1);
    drain("held");
    chk("occ_held", 64'(bus.occupancy), 64'd0);

    // Bad opcode refused, following push and pop unaffected
    send(2'd3, 5'd20, 32'h55, 1'b0, 32'd0, 1'b1, 2);
    drain("bad_op");
    send(2'd1, 5'd21, 32'd77, 1'b1, 32'd1, 1'b0, 8);
    drain("after_bad");
    send(2'd2, 5'd22, 32'd0, 1'b1, 32'd77, 1'b0, -1);
    drain("pop_77");
    chk("occ_bad_op", 64'(bus.occupancy), 64'd0);

    // Reset while a pop is waiting on the heap: no write-back survives
    send(2'd1, 5'd24, 32'd11, 1'b1, 32'd1, 1'b0, -1);
    drain("pre_reset");
    send(2'd2, 5'd25, 32'd0, 1'b1, 32'd11, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wb_q.delete();
    hp_q.delete();
    #1;
    chk("mid_rst_wb", 64'({bus.wb_v, bus.wb_rd, bus.wb_data, bus.wb_err}), 64'd0);
    chk("mid_rst_hp", 64'({bus.hp_v, bus.hp_op, bus.hp_rd, bus.hp_data}), 64'd0);
    chk("mid_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_idle", 64'(bus.idle), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("post_rst_idle", 64'(bus.idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
